// File: rtl/freelist_ctrl.sv
// freelist_ctrl: rename-stage free-list allocate/release controller with a pending-free queue.
// Optional FREELIST_CTRL_BYPASS_EN: grant straight from the queue head when the list is empty.
module freelist_ctrl #(
    parameter int WIDTH  = 6,
    parameter int SIZE   = 2**WIDTH,
    parameter int QDEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_req,
    output logic [1:0]       o_gnt,
    output logic [WIDTH-1:0] o_tag,
    input  logic [1:0]       i_free_vld,
    input  logic [WIDTH-1:0] i_free_tag0,
    input  logic [WIDTH-1:0] i_free_tag1,
    output logic             o_free_rdy,
    output logic             o_fl_re,
    output logic             o_fl_we,
    output logic [WIDTH-1:0] o_fl_wdata,
    input  logic [WIDTH-1:0] i_fl_rdata,
    output logic [WIDTH:0]   o_count,
    output logic             o_empty
);
    localparam int QW = $clog2(QDEPTH);
    localparam logic [WIDTH:0] CNT_MAX = (WIDTH+1)'(SIZE);
    localparam logic [QW:0]    OCC_LIM = (QW+1)'(QDEPTH-2);
    logic [WIDTH:0]   count;
    logic [WIDTH-1:0] q_mem [QDEPTH];
    logic [QW-1:0]    rd_ptr, wr_ptr;
    logic [QW:0]      occ;
    logic             rr;
    logic             q_nempty, bypass, can_gnt, pop, enq0, enq1;
    logic [1:0]       gnt_raw;
    assign q_nempty = occ != '0;
`ifdef FREELIST_CTRL_BYPASS_EN
    assign bypass = count == '0 && q_nempty;
`else
    assign bypass = 1'b0;
`endif
    assign can_gnt = i_rst_n && (count != '0 || bypass);
    always_comb begin
        gnt_raw    = &i_req ? (rr ? 2'b10 : 2'b01) : i_req;
        o_gnt      = can_gnt ? gnt_raw : 2'b00;
        o_tag      = bypass ? q_mem[rd_ptr] : i_fl_rdata;
        o_fl_re    = |o_gnt && !bypass;
        // a bypass grant consumes the queue head, so nothing is pushed that cycle
        o_fl_we    = i_rst_n && q_nempty && count != CNT_MAX && !(bypass && |o_gnt);
        o_fl_wdata = q_mem[rd_ptr];
        o_free_rdy = i_rst_n && occ <= OCC_LIM;
        pop        = o_fl_we || (bypass && |o_gnt);
        enq0       = o_free_rdy && i_free_vld[0];
        enq1       = o_free_rdy && i_free_vld[1];
    end
    assign o_count = count;
    assign o_empty = count == '0;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count  <= CNT_MAX;
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            rr     <= 1'b0;
        end else begin
            count  <= count + (WIDTH+1)'(o_fl_we) - (WIDTH+1)'(o_fl_re);
            rd_ptr <= rd_ptr + QW'(pop);
            wr_ptr <= wr_ptr + QW'(enq0) + QW'(enq1);
            occ    <= occ + (QW+1)'(enq0) + (QW+1)'(enq1) - (QW+1)'(pop);
            if (&i_req && |o_gnt)
                rr <= ~rr;
        end
    end
    always_ff @(posedge i_clk) begin
        if (enq0)
            q_mem[wr_ptr] <= i_free_tag0;
        if (enq1)
            q_mem[wr_ptr + QW'(enq0)] <= i_free_tag1;
    end
endmodule

// File: tb/tb_freelist_ctrl.sv
// tb_freelist_ctrl: directed bench for freelist_ctrl (WIDTH=3, SIZE=8, QDEPTH=4)
// with a behavioural free-list FIFO on the push/pop ports.
module tb_freelist_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = '0, gnt, free_vld = '0;
    logic [2:0] tag, free_tag0 = '0, free_tag1 = '0, fl_wdata, fl_rdata;
    logic       free_rdy, fl_re, fl_we, empty;
    logic [3:0] count;
    int         n_chk = 0, n_err = 0;
    logic [2:0] fl [8];
    logic [2:0] fl_head, fl_tail;

    freelist_ctrl #(.WIDTH(3), .SIZE(8), .QDEPTH(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_gnt(gnt), .o_tag(tag),
        .i_free_vld(free_vld), .i_free_tag0(free_tag0), .i_free_tag1(free_tag1),
        .o_free_rdy(free_rdy), .o_fl_re(fl_re), .o_fl_we(fl_we), .o_fl_wdata(fl_wdata),
        .i_fl_rdata(fl_rdata), .o_count(count), .o_empty(empty)
    );

    always #5 clk = ~clk;

    assign fl_rdata = fl[fl_head];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) fl[i] <= 3'(i);
            fl_head <= '0;
            fl_tail <= '0;
        end else begin
            if (fl_re) fl_head <= fl_head + 3'd1;
            if (fl_we) begin
                fl[fl_tail] <= fl_wdata;
                fl_tail     <= fl_tail + 3'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] v, input logic [2:0] t0, input logic [2:0] t1);
        req = r; free_vld = v; free_tag0 = t0; free_tag1 = t1;
        #1;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_re", 32'(fl_re), 0);
        chk("rst_we", 32'(fl_we), 0);
        chk("rst_rdy", 32'(free_rdy), 0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_count", 32'(count), 8);
        chk("post_rst_rdy", 32'(free_rdy), 1);
        chk("post_rst_empty", 32'(empty), 0);
        // single lane drains the whole list
        for (int k = 0; k < 9; k++) begin
            drive(2'b01, 2'b00, 3'd0, 3'd0);
            if (k < 8) begin
                chk("t1_gnt", 32'(gnt), 1);
                chk("t1_tag", 32'(tag), 32'(k));
                chk("t1_count", 32'(count), 32'(8 - k));
            end else begin
                chk("t1_gnt_none", 32'(gnt), 0);
                chk("t1_empty", 32'(empty), 1);
                chk("t1_re", 32'(fl_re), 0);
            end
            tick();
        end
        // two frees in one cycle, drained one per cycle, reused in order
        drive(2'b00, 2'b11, 3'd5, 3'd6);
        chk("t3_we0", 32'(fl_we), 0);
        tick();
        drive(2'b00, 2'b00, 3'd0, 3'd0);
        chk("t3_we5", 32'(fl_we), 1);
        chk("t3_wd5", 32'(fl_wdata), 5);
        chk("t3_cnt0", 32'(count), 0);
        tick();
        drive(2'b01, 2'b00, 3'd0, 3'd0);
        chk("t3_we6", 32'(fl_we), 1);
        chk("t3_wd6", 32'(fl_wdata), 6);
        chk("t3_cnt1", 32'(count), 1);
        chk("t3_gnt5", 32'(gnt), 1);
        chk("t3_tag5", 32'(tag), 5);
        tick();
        drive(2'b01, 2'b00, 3'd0, 3'd0);
        chk("t3_cnt1b", 32'(count), 1);
        chk("t3_tag6", 32'(tag), 6);
        chk("t3_we_idle", 32'(fl_we), 0);
        tick();
        drive(2'b00, 2'b00, 3'd0, 3'd0);
        chk("t3_cnt_end", 32'(count), 0);
        tick();
        // queue fill: ready drops at occupancy 3, ignored frees while not ready
        drive(2'b00, 2'b11, 3'd1, 3'd2);
        chk("t4_rdyA", 32'(free_rdy), 1);
        tick();
        drive(2'b00, 2'b11, 3'd3, 3'd4);
        chk("t4_rdyB", 32'(free_rdy), 1);
        chk("t4_wdB", 32'(fl_wdata), 1);
        tick();
        drive(2'b00, 2'b11, 3'd7, 3'd7);
        chk("t4_rdyC", 32'(free_rdy), 0);
        chk("t4_wdC", 32'(fl_wdata), 2);
        tick();
        drive(2'b00, 2'b00, 3'd0, 3'd0);
        chk("t4_rdyD", 32'(free_rdy), 1);
        chk("t4_wdD", 32'(fl_wdata), 3);
        tick();
        chk("t4_wdE", 32'(fl_wdata), 4);
        chk("t4_cntE", 32'(count), 3);
        tick();
        chk("t4_weF", 32'(fl_we), 0);
        chk("t4_cntF", 32'(count), 4);
        // round robin with both lanes requesting
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 2'b00, 3'd0, 3'd0);
            chk("t2_gnt", 32'(gnt), (k % 2 == 0) ? 1 : 2);
            chk("t2_tag", 32'(tag), 32'(k + 1));
            tick();
        end
        drive(2'b00, 2'b00, 3'd0, 3'd0);
        chk("t2_cnt", 32'(count), 0);
        // single free while empty, then lane1 requests
        drive(2'b00, 2'b01, 3'd3, 3'd0);
        tick();
        drive(2'b10, 2'b00, 3'd0, 3'd0);
`ifdef FREELIST_CTRL_BYPASS_EN
        chk("t6_byp_gnt", 32'(gnt), 2);
        chk("t6_byp_tag", 32'(tag), 3);
        chk("t6_byp_we", 32'(fl_we), 0);
        chk("t6_byp_re", 32'(fl_re), 0);
        tick();
        drive(2'b00, 2'b00, 3'd0, 3'd0);
        chk("t6_byp_cnt", 32'(count), 0);
        chk("t6_byp_we2", 32'(fl_we), 0);
`else
        chk("t6_gnt_none", 32'(gnt), 0);
        chk("t6_we", 32'(fl_we), 1);
        chk("t6_wd", 32'(fl_wdata), 3);
        tick();
        drive(2'b10, 2'b00, 3'd0, 3'd0);
        chk("t6_gnt", 32'(gnt), 2);
        chk("t6_tag", 32'(tag), 3);
        chk("t6_cnt", 32'(count), 1);
        tick();
        drive(2'b00, 2'b00, 3'd0, 3'd0);
        chk("t6_cnt_end", 32'(count), 0);
`endif
        tick();
        // build occupancy 3 / count 2, then reset mid-cycle
        drive(2'b00, 2'b11, 3'd1, 3'd2);
        tick();
        drive(2'b00, 2'b11, 3'd3, 3'd4);
        tick();
        drive(2'b00, 2'b00, 3'd0, 3'd0);
        tick();
        drive(2'b01, 2'b11, 3'd5, 3'd6);
        chk("t5_gntD", 32'(gnt), 1);
        tick();
        drive(2'b01, 2'b00, 3'd0, 3'd0);
        chk("t5_cnt", 32'(count), 2);
        chk("t5_rdy", 32'(free_rdy), 0);
        chk("t5_we", 32'(fl_we), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_gnt", 32'(gnt), 0);
        chk("t5_rst_we", 32'(fl_we), 0);
        chk("t5_rst_cnt", 32'(count), 8);
        tick();
        rst_n = 1'b1;
        drive(2'b11, 2'b00, 3'd0, 3'd0);
        chk("t5_cnt8", 32'(count), 8);
        chk("t5_rdy1", 32'(free_rdy), 1);
        chk("t5_qempty", 32'(fl_we), 0);
        chk("t5_rr0", 32'(gnt), 1);
        chk("t5_tag0", 32'(tag), 0);
        tick();
        chk("t5_rr1", 32'(gnt), 2);
        chk("t5_tag1", 32'(tag), 1);
        req = 2'b00;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
